// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte sources
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int LOCK_EN      = 1,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   uart_start_tx,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy,
    input  logic                   uart_tx_done,
    output logic [ID_W-1:0]        grant_id,
    output logic                   active,
    output logic                   locked,
    output logic                   err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [7:0]      TMO     = 8'(BUSY_TIMEOUT);
    localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NUM_REQ);

    state_t               state, state_d;
    logic [ID_W-1:0]      rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]      grant_d;
    logic [7:0]           data_d;
    logic [7:0]           tmo_cnt, tmo_cnt_d;
    logic                 locked_d;
    logic                 start_d;
    logic [NUM_REQ-1:0]   ack_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant_mask;
    logic [NUM_REQ-1:0]   winner_mask;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      cand;
    logic [ID_W:0]        sum;
    logic                 found;
    logic [7:0]           sel_data;

    assign active     = (state != IDLE);
    assign grant_mask = NUM_REQ'(1) << grant_id;

    // While a packet is locked only the owning source may win.
    always_comb begin
        eligible = locked ? (req & grant_mask) : req;
        winner   = '0;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            cand = sum[ID_W-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign winner_mask = NUM_REQ'(1) << winner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        grant_d     = grant_id;
        data_d      = uart_data;
        locked_d    = locked;
        tmo_cnt_d   = tmo_cnt;
        start_d     = 1'b0;
        ack_d       = '0;
        err_timeout = 1'b0;
        case (state)
            IDLE: begin
                // Owner dropped its request mid-packet: release, grant nobody this cycle.
                if (locked && !req[grant_id]) begin
                    locked_d = 1'b0;
                end else if (found) begin
                    grant_d = winner;
                    data_d  = sel_data;
                    start_d = 1'b1;
                    ack_d   = winner_mask;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rr_ptr_d  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                if (LOCK_EN != 0) begin
                    locked_d = !req_last[grant_id];
                end
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt == TMO) begin
                    err_timeout = 1'b1;
                    locked_d    = 1'b0;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (uart_tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            grant_id      <= '0;
            uart_data     <= 8'h00;
            locked        <= 1'b0;
            tmo_cnt       <= '0;
            uart_start_tx <= 1'b0;
            ack           <= '0;
        end else begin
            rr_ptr        <= rr_ptr_d;
            grant_id      <= grant_d;
            uart_data     <= data_d;
            locked        <= locked_d;
            tmo_cnt       <= tmo_cnt_d;
            uart_start_tx <= start_d;
            ack           <= ack_d;
        end
    end

endmodule
